// File: rtl/shared_mult_arbiter.sv
// shared_mult_arbiter
// One pipelined unsigned WIDTH x WIDTH multiplier, time-shared between two
// requesters. Round-robin arbitration picks the requester, and each requester
// gets its product back on its own valid/ready result channel.
//
// Ports
//   clk_in, rst_n_in               clock, asynchronous active-low reset
//   a0_in, b0_in, req0_valid_in    requester 0 operands and valid
//   req0_ready_out                 requester 0 operands accepted this cycle
//   a1_in, b1_in, req1_valid_in    requester 1 operands and valid
//   req1_ready_out                 requester 1 operands accepted this cycle
//   q0_out, q0_valid_out           requester 0 product and valid
//   q0_ready_in                    requester 0 consumes the product
//   q1_out, q1_valid_out           requester 1 product and valid
//   q1_ready_in                    requester 1 consumes the product
//   busy_out                       some channel has an operation outstanding
//
// PIPE_STAGES counts the registers from operand acceptance to the result
// register, inclusive, and must be at least 1.
module shared_mult_arbiter #(
    parameter int WIDTH       = 8,
    parameter int PIPE_STAGES = 2
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic [WIDTH-1:0]   a0_in,
    input  logic [WIDTH-1:0]   b0_in,
    input  logic               req0_valid_in,
    output logic               req0_ready_out,
    input  logic [WIDTH-1:0]   a1_in,
    input  logic [WIDTH-1:0]   b1_in,
    input  logic               req1_valid_in,
    output logic               req1_ready_out,
    output logic [2*WIDTH-1:0] q0_out,
    output logic               q0_valid_out,
    input  logic               q0_ready_in,
    output logic [2*WIDTH-1:0] q1_out,
    output logic               q1_valid_out,
    input  logic               q1_ready_in,
    output logic               busy_out
);

    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        CH_IDLE = 2'd0,
        CH_BUSY = 2'd1,
        CH_DONE = 2'd2
    } ch_state_t;

    ch_state_t        state_q [2];
    ch_state_t        state_d [2];
    logic [1:0]       req_valid;
    logic [1:0]       res_ready;
    logic [1:0]       elig;
    logic [1:0]       grant;
    logic [1:0]       land;
    logic [1:0]       consume;
    logic             last_grant;
    logic             xfer;
    logic             xfer_ch;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic [PW-1:0]    prod_c;
    logic [PW-1:0]    prod_out;
    logic             vld_out;
    logic             tag_out;
    logic [PW-1:0]    q_q [2];

    function automatic logic [PW-1:0] full_product(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        return PW'(a) * PW'(b);
    endfunction

    assign req_valid = {req1_valid_in, req0_valid_in};
    assign res_ready = {q1_ready_in, q0_ready_in};

    // Arbitration. Holding off eligibility while reset is asserted keeps the
    // ready outputs low for the whole reset period.
    always_comb begin
        elig  = '0;
        grant = '0;
        for (int i = 0; i < 2; i++) begin
            elig[i] = rst_n_in && req_valid[i] && (state_q[i] == CH_IDLE);
        end
        if (elig == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end else begin
            grant = elig;
        end
    end

    assign xfer    = |grant;
    assign xfer_ch = grant[1];
    assign a_sel   = xfer_ch ? a1_in : a0_in;
    assign b_sel   = xfer_ch ? b1_in : b0_in;
    assign prod_c  = full_product(a_sel, b_sel);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            last_grant <= 1'b1;
        end else if (xfer) begin
            last_grant <= xfer_ch;
        end
    end

    // Stage p0 .. p(PIPE_STAGES-2): product and channel tag in flight.
    // Only the valid bits are reset; the data follows whatever they qualify.
    generate
        if (PIPE_STAGES == 1) begin : g_direct
            assign prod_out = prod_c;
            assign vld_out  = xfer;
            assign tag_out  = xfer_ch;
        end else begin : g_pipe
            localparam int D = PIPE_STAGES - 1;
            logic [PW-1:0] prod_p [D];
            logic          tag_p  [D];
            logic          vld_p  [D];

            always_ff @(posedge clk_in or negedge rst_n_in) begin
                if (!rst_n_in) begin
                    for (int k = 0; k < D; k++) begin
                        vld_p[k] <= 1'b0;
                    end
                end else begin
                    vld_p[0] <= xfer;
                    for (int k = 1; k < D; k++) begin
                        vld_p[k] <= vld_p[k-1];
                    end
                end
            end

            always_ff @(posedge clk_in) begin
                prod_p[0] <= prod_c;
                tag_p[0]  <= xfer_ch;
                for (int k = 1; k < D; k++) begin
                    prod_p[k] <= prod_p[k-1];
                    tag_p[k]  <= tag_p[k-1];
                end
            end

            assign prod_out = prod_p[D-1];
            assign vld_out  = vld_p[D-1];
            assign tag_out  = tag_p[D-1];
        end
    endgenerate

    assign land[0] = vld_out & ~tag_out;
    assign land[1] = vld_out & tag_out;

    always_comb begin
        consume = '0;
        for (int i = 0; i < 2; i++) begin
            consume[i] = (state_q[i] == CH_DONE) && res_ready[i];
        end
    end

    // Result registers: written when the channel's product leaves the
    // pipeline, otherwise hold the last product.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            q_q[0] <= '0;
            q_q[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (land[i]) begin
                    q_q[i] <= prod_out;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q[0] <= CH_IDLE;
            state_q[1] <= CH_IDLE;
        end else begin
            state_q[0] <= state_d[0];
            state_q[1] <= state_d[1];
        end
    end

    // With a single stage the product lands on the accepting edge, so IDLE
    // can go straight to DONE.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                CH_IDLE: begin
                    if (land[i]) begin
                        state_d[i] = CH_DONE;
                    end else if (grant[i]) begin
                        state_d[i] = CH_BUSY;
                    end
                end
                CH_BUSY: begin
                    if (land[i]) begin
                        state_d[i] = CH_DONE;
                    end
                end
                CH_DONE: begin
                    if (consume[i]) begin
                        state_d[i] = CH_IDLE;
                    end
                end
                default: state_d[i] = CH_IDLE;
            endcase
        end
    end

    always_comb begin
        req0_ready_out = grant[0];
        req1_ready_out = grant[1];
        q0_valid_out   = (state_q[0] == CH_DONE);
        q1_valid_out   = (state_q[1] == CH_DONE);
        q0_out         = q_q[0];
        q1_out         = q_q[1];
        busy_out       = (state_q[0] != CH_IDLE) || (state_q[1] != CH_IDLE);
    end

endmodule

// File: tb/tb_shared_mult_arbiter.sv
// tb_shared_mult_arbiter
// Drives directed and randomized traffic into shared_mult_arbiter. A stimulus
// process predicts which requester is accepted each cycle and queues the
// expected product; a monitor process checks result valid timing, product
// values, held values and busy against those queues.
module tb_shared_mult_arbiter;

    localparam int W  = 8;
    localparam int P  = 2;
    localparam int PW = 2 * W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [PW-1:0] q0, q1;
    logic          q0_valid, q1_valid;
    logic          q0_ready = 1'b0, q1_ready = 1'b0;
    logic          busy;

    always #5 clk = ~clk;

    shared_mult_arbiter #(.WIDTH(W), .PIPE_STAGES(P)) dut (
        .clk_in(clk), .rst_n_in(rst_n),
        .a0_in(a0), .b0_in(b0), .req0_valid_in(req0_valid), .req0_ready_out(req0_ready),
        .a1_in(a1), .b1_in(b1), .req1_valid_in(req1_valid), .req1_ready_out(req1_ready),
        .q0_out(q0), .q0_valid_out(q0_valid), .q0_ready_in(q0_ready),
        .q1_out(q1), .q1_valid_out(q1_valid), .q1_ready_in(q1_ready),
        .busy_out(busy)
    );

    typedef struct {
        logic [31:0] prod;
        int          acc;
    } op_t;

    op_t         exp_q [2][$];
    logic [31:0] last_q [2];
    int          last_grant_m = 1;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    logic        rst_g = 1'b0;
    logic        acc_g [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, want);
        end
    endtask

    function automatic logic [31:0] ref_mul(input int unsigned x, input int unsigned y);
        return x * y;
    endfunction

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            default: return W'($urandom);
        endcase
    endfunction

    // One cycle of stimulus: apply inputs after the falling edge, then
    // predict the arbitration outcome for the coming rising edge.
    task automatic step(input logic v0, input logic [W-1:0] x0, input logic [W-1:0] y0,
                        input logic v1, input logic [W-1:0] x1, input logic [W-1:0] y1,
                        input logic r0, input logic r1);
        logic e0, e1, er0, er1;
        op_t  op;
        @(negedge clk);
        rst_n = rst_g;
        if (!rst_g) begin
            exp_q[0].delete();
            exp_q[1].delete();
            last_q[0]    = '0;
            last_q[1]    = '0;
            last_grant_m = 1;
        end
        req0_valid = v0; a0 = x0; b0 = y0;
        req1_valid = v1; a1 = x1; b1 = y1;
        q0_ready   = r0; q1_ready = r1;
        #1;
        e0  = rst_g && v0 && (exp_q[0].size() == 0);
        e1  = rst_g && v1 && (exp_q[1].size() == 0);
        er0 = e0 && (!e1 || last_grant_m != 0);
        er1 = e1 && (!e0 || last_grant_m != 1);
        check("req0_ready", 32'(req0_ready), 32'(er0));
        check("req1_ready", 32'(req1_ready), 32'(er1));
        if (er0) begin
            op.prod = ref_mul(int'(x0), int'(y0));
            op.acc  = cyc;
            exp_q[0].push_back(op);
            last_grant_m = 0;
        end
        if (er1) begin
            op.prod = ref_mul(int'(x1), int'(y1));
            op.acc  = cyc;
            exp_q[1].push_back(op);
            last_grant_m = 1;
        end
        acc_g[0] = er0;
        acc_g[1] = er1;
    endtask

    // Monitor: result valid appears P cycles after the accepting cycle and
    // holds until consumed; q holds its last product otherwise.
    initial begin : monitor
        logic          ev, busy_e, v, r;
        logic [PW-1:0] q;
        forever begin
            @(negedge clk);
            #2;
            busy_e = 1'b0;
            for (int i = 0; i < 2; i++) begin
                if (exp_q[i].size() != 0 && exp_q[i][0].acc < cyc) busy_e = 1'b1;
            end
            check("busy", 32'(busy), 32'(busy_e));
            for (int i = 0; i < 2; i++) begin
                v  = (i == 0) ? q0_valid : q1_valid;
                r  = (i == 0) ? q0_ready : q1_ready;
                q  = (i == 0) ? q0 : q1;
                ev = (exp_q[i].size() != 0) && (cyc >= exp_q[i][0].acc + P);
                check(i == 0 ? "q0_valid" : "q1_valid", 32'(v), 32'(ev));
                if (ev) begin
                    check(i == 0 ? "q0_product" : "q1_product", 32'(q), exp_q[i][0].prod);
                    if (r) begin
                        last_q[i] = exp_q[i][0].prod;
                        void'(exp_q[i].pop_front());
                    end
                end else begin
                    check(i == 0 ? "q0_hold" : "q1_hold", 32'(q), last_q[i]);
                end
            end
        end
    end

    initial begin : stimulus
        logic [W-1:0] ra [2];
        logic [W-1:0] rb [2];
        logic         rv [2];
        logic         rr [2];
        int           mode [2];
        logic [W-1:0] pa [2];
        logic [W-1:0] pb [2];
        int           k;

        last_q[0] = '0;
        last_q[1] = '0;
        acc_g[0]  = 1'b0;
        acc_g[1]  = 1'b0;

        // Reset held with every valid asserted.
        rst_g = 1'b0;
        repeat (3) step(1, 8'd1, 8'd1, 1, 8'd2, 8'd2, 1, 1);
        rst_g = 1'b1;

        // Single op with the sink stalled, then consumed.
        step(1, 8'd13, 8'd11, 0, 8'd0, 8'd0, 0, 0);
        repeat (6) step(0, 8'd0, 8'd0, 0, 8'd0, 8'd0, 0, 0);
        repeat (3) step(0, 8'd0, 8'd0, 0, 8'd0, 8'd0, 1, 1);

        // Tie straight after reset, then a second tie.
        rst_g = 1'b0;
        step(0, 8'd0, 8'd0, 0, 8'd0, 8'd0, 1, 1);
        rst_g = 1'b1;
        step(1, 8'd3, 8'd4, 1, 8'd5, 8'd6, 1, 1);
        step(0, 8'd3, 8'd4, 1, 8'd5, 8'd6, 1, 1);
        repeat (4) step(0, 8'd0, 8'd0, 0, 8'd0, 8'd0, 1, 1);
        step(1, 8'd1, 8'd2, 1, 8'd3, 8'd4, 1, 1);
        step(0, 8'd1, 8'd2, 1, 8'd3, 8'd4, 1, 1);
        repeat (4) step(0, 8'd0, 8'd0, 0, 8'd0, 8'd0, 1, 1);

        // Largest operands.
        step(0, 8'd0, 8'd0, 1, 8'd255, 8'd255, 1, 1);
        repeat (4) step(0, 8'd0, 8'd0, 0, 8'd0, 8'd0, 1, 1);

        // Channel 1 stalled in DONE while channel 0 streams two products.
        step(0, 8'd0, 8'd0, 1, 8'd7, 8'd8, 1, 0);
        pa[0] = 8'd2; pb[0] = 8'd7;
        pa[1] = 8'd9; pb[1] = 8'd9;
        k = 0;
        for (int c = 0; c < 12; c++) begin
            if (k < 2) step(1, pa[k], pb[k], 1, 8'd7, 8'd8, 1, 0);
            else       step(0, 8'd0, 8'd0, 1, 8'd7, 8'd8, 1, 0);
            if (acc_g[0]) k++;
        end
        check("ch0_stream_count", 32'(k), 32'd2);
        repeat (6) step(0, 8'd0, 8'd0, 0, 8'd0, 8'd0, 1, 1);

        // Reset one cycle after an accept: the operation must vanish.
        step(1, 8'd5, 8'd5, 0, 8'd0, 8'd0, 1, 1);
        rst_g = 1'b0;
        step(0, 8'd0, 8'd0, 0, 8'd0, 8'd0, 1, 1);
        rst_g = 1'b1;
        repeat (5) step(0, 8'd0, 8'd0, 0, 8'd0, 8'd0, 1, 1);

        // Randomized traffic with changing sink behaviour and occasional reset.
        for (int i = 0; i < 2; i++) begin
            rv[i] = 1'b0; ra[i] = '0; rb[i] = '0; rr[i] = 1'b1; mode[i] = 0;
        end
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!(rv[i] && !acc_g[i] && $urandom_range(0, 9) < 8)) begin
                    rv[i] = ($urandom_range(0, 2) != 0);
                    ra[i] = rnd_op();
                    rb[i] = rnd_op();
                end
                if (c % 37 == 0) mode[i] = int'($urandom_range(0, 2));
                rr[i] = (mode[i] == 0) ? 1'b1 :
                        (mode[i] == 1) ? ($urandom_range(0, 1) == 1) : 1'b0;
            end
            rst_g = !(c % 500 == 250);
            step(rv[0], ra[0], rb[0], rv[1], ra[1], rb[1], rr[0], rr[1]);
        end

        // Drain: every accepted operation must have been delivered.
        rst_g = 1'b1;
        repeat (10) step(0, 8'd0, 8'd0, 0, 8'd0, 8'd0, 1, 1);
        check("drain_outstanding", 32'(exp_q[0].size() + exp_q[1].size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
